// File: rtl/sram_port0_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port0_arbiter
//
// Purpose:
//   Shares port 0 of a single-port SRAM macro between two requesters, A (CPU)
//   and B (DMA). Only one access is in flight at a time. Each access walks
//   IDLE -> ACCESS -> WAIT -> DONE -> IDLE, and every non-IDLE state lasts
//   exactly one cycle. Simultaneous requests are resolved round-robin.
//
// Parameters:
//   ADDR_WIDTH  word address width
//   DATA_WIDTH  data width
//   NUM_WMASKS  number of byte enables (DATA_WIDTH/8)
//
// Ports:
//   clk, resetn            sole clock, asynchronous active-low reset
//   a_valid / b_valid      request valid from A / B
//   a_ready / b_ready      request accepted this cycle (combinational, IDLE only)
//   a_we / b_we            1 = write, 0 = read
//   a_wmask / b_wmask      byte enables for writes
//   a_addr / b_addr        word address
//   a_wdata / b_wdata      write data
//   a_rvalid / b_rvalid    one-cycle completion pulse (reads and writes)
//   a_rdata / b_rdata      read data, held until that requester's next read
//   sram_csb0              active-low chip select to the SRAM
//   sram_web0              active-low write enable to the SRAM
//   sram_wmask0            byte write mask to the SRAM
//   sram_addr0             SRAM address
//   sram_din0              SRAM write data
//   sram_dout0             SRAM read data
//   busy                   high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module sram_port0_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,

  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,

  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Round-robin pointer: 1 means B was granted most recently, so A wins a tie.
  logic r_lastGrantB;

  // Owner of the transaction in flight (0 = A, 1 = B) and whether it is a read.
  logic r_ownerB;
  logic r_isRead;

  logic                  r_sramCsb;
  logic                  r_sramWeb;
  logic [NUM_WMASKS-1:0] r_sramWmask;
  logic [ADDR_WIDTH-1:0] r_sramAddr;
  logic [DATA_WIDTH-1:0] r_sramDin;

  logic                  r_aRvalid;
  logic                  r_bRvalid;
  logic [DATA_WIDTH-1:0] r_aRdata;
  logic [DATA_WIDTH-1:0] r_bRdata;

  logic                  w_grantA;
  logic                  w_grantB;
  logic                  w_accept;
  logic                  w_reqWe;
  logic [NUM_WMASKS-1:0] w_reqWmask;
  logic [ADDR_WIDTH-1:0] w_reqAddr;
  logic [DATA_WIDTH-1:0] w_reqWdata;

  // Grants are only ever issued from IDLE. A lone request always wins; on a
  // tie the requester that was not granted last time wins. The two grant
  // terms are mutually exclusive by construction.
  always_comb begin
    w_grantA = 1'b0;
    w_grantB = 1'b0;
    if (r_state == IDLE) begin
      w_grantA = a_valid && (!b_valid || r_lastGrantB);
      w_grantB = b_valid && (!a_valid || !r_lastGrantB);
    end
  end

  assign w_accept = w_grantA || w_grantB;

  // The winner's request fields, selected so they can be loaded directly into
  // the SRAM-facing registers at the accept edge.
  always_comb begin
    w_reqWe    = a_we;
    w_reqWmask = a_wmask;
    w_reqAddr  = a_addr;
    w_reqWdata = a_wdata;
    if (w_grantB) begin
      w_reqWe    = b_we;
      w_reqWmask = b_wmask;
      w_reqAddr  = b_addr;
      w_reqWdata = b_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: each non-IDLE state lasts one cycle; DONE always
  // returns to IDLE so there is a single IDLE cycle between accesses.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = ACCESS;
      ACCESS:  w_nextState = WAIT;
      WAIT:    w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Latch who owns the transaction and update the round-robin pointer, only
  // when a request is actually accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lastGrantB <= 1'b1;
      r_ownerB     <= 1'b0;
      r_isRead     <= 1'b0;
    end else if (w_accept) begin
      r_lastGrantB <= w_grantB;
      r_ownerB     <= w_grantB;
      r_isRead     <= !w_reqWe;
    end
  end

  // SRAM-facing registers. They are loaded at the accept edge so that the
  // whole ACCESS cycle presents a clean registered command; the SRAM samples
  // it at the edge ending ACCESS, after which select/write-enable return
  // inactive. Address, data and mask simply hold their last value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sramCsb   <= 1'b1;
      r_sramWeb   <= 1'b1;
      r_sramWmask <= '0;
      r_sramAddr  <= '0;
      r_sramDin   <= '0;
    end else if (w_accept) begin
      r_sramCsb   <= 1'b0;
      r_sramWeb   <= !w_reqWe;
      r_sramWmask <= w_reqWmask;
      r_sramAddr  <= w_reqAddr;
      r_sramDin   <= w_reqWdata;
    end else if (r_state == ACCESS) begin
      r_sramCsb   <= 1'b1;
      r_sramWeb   <= 1'b1;
    end
  end

  // Completion: the SRAM output has had the whole WAIT cycle to settle, so
  // read data is captured at the edge ending WAIT, and the owner's rvalid is
  // raised for the DONE cycle only. Writes leave rdata untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_aRvalid <= 1'b0;
      r_bRvalid <= 1'b0;
      r_aRdata  <= '0;
      r_bRdata  <= '0;
    end else begin
      r_aRvalid <= (r_state == WAIT) && !r_ownerB;
      r_bRvalid <= (r_state == WAIT) && r_ownerB;
      if ((r_state == WAIT) && r_isRead) begin
        if (r_ownerB) begin
          r_bRdata <= sram_dout0;
        end else begin
          r_aRdata <= sram_dout0;
        end
      end
    end
  end

  assign a_ready     = w_grantA;
  assign b_ready     = w_grantB;
  assign a_rvalid    = r_aRvalid;
  assign b_rvalid    = r_bRvalid;
  assign a_rdata     = r_aRdata;
  assign b_rdata     = r_bRdata;
  assign sram_csb0   = r_sramCsb;
  assign sram_web0   = r_sramWeb;
  assign sram_wmask0 = r_sramWmask;
  assign sram_addr0  = r_sramAddr;
  assign sram_din0   = r_sramDin;
  assign busy        = (r_state != IDLE);

endmodule
